l2cache_ctrl_nway: RTL and testbench
====================================

Name: l2cache_ctrl_nway

Overview:
Parametrised N-way set-associative successor to the direct-mapped L2 cache controller FSM. It sequences hit service, dirty-victim writeback and line fill against physical memory. It owns per-set tree-PLRU replacement state and drives one-hot way selects to the L2 datapath. It also keeps saturating hit/miss/writeback performance counters.

Parameters:
NUM_WAYS, 4, associativity; power of 2, >=2
NUM_SETS, 8, number of sets; power of 2
SET_W, $clog2(NUM_SETS), set index width (derived)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
mem_read  in  1  read request from L1/arbiter; held until mem_resp
mem_write  in  1  write request; held until mem_resp
set_idx  in  SET_W  set index of current request (stable while request held)
mem_resp  out  1  request complete, one-cycle pulse
hit_vec  in  NUM_WAYS  per-way tag match & valid from datapath
valid_vec  in  NUM_WAYS  per-way valid bits of indexed set
dirty_vec  in  NUM_WAYS  per-way dirty bits of indexed set
pmem_resp  in  1  physical memory done
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_addr_sel  out  1  1 = victim tag address, 0 = request address
way_sel  out  NUM_WAYS  one-hot way enable for all loads
load_tag  out  1  write tag of way_sel
load_data  out  1  write data of way_sel
load_valid  out  1  set valid of way_sel
data_in_sel  out  1  1 = CPU write data, 0 = pmem line
set_dirty  out  1  set dirty of way_sel
clr_dirty  out  1  clear dirty of way_sel
miss_pulse  out  1  one-cycle pulse per detected miss
clr_counters  in  1  synchronous counter clear
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter
wb_count  out  CNT_W  saturating writeback counter

Behaviour:
- Reset (rst_n low, async): state=IDLE; all PLRU bits 0; counters 0; victim register 0. Outputs are combinational from state, so pmem_read/pmem_write/mem_resp/load_*/set_dirty/clr_dirty/miss_pulse are 0 immediately. way_sel=0 and pmem_addr_sel=1 during reset. Reset mid-miss abandons the transfer without a response.
- Request = mem_read|mem_write. When both are asserted, treat as write. More than one bit in hit_vec is illegal; use the lowest set bit.
- States: IDLE, WRITEBACK, FILL.
- IDLE, request and |hit_vec:
  - mem_resp=1 in the same cycle; way_sel=hit way.
  - Write additionally asserts load_data=1, data_in_sel=1, set_dirty=1.
  - PLRU[set_idx] is updated toward the hit way at the clock edge; hit_count+1.
- IDLE, request and no hit:
  - miss_pulse=1; miss_count+1.
  - Victim = lowest-index way with valid_vec=0. If all ways are valid, victim = PLRU victim of set_idx. The victim is latched.
  - Next state is WRITEBACK if the chosen victim is valid and dirty, else FILL. No datapath loads are asserted this cycle.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=latched victim. On pmem_resp: clr_dirty=1, wb_count+1, go to FILL.
- FILL: pmem_read=1, pmem_addr_sel=0, data_in_sel=0, way_sel=victim. On pmem_resp: load_tag=1, load_data=1, load_valid=1, clr_dirty=1, go to IDLE.
- After FILL the request hits in IDLE on the next cycle and completes there. Minimum miss latency = 1 (IDLE) + fill cycles + 1.
- A request dropped mid-miss: the miss still runs to completion with no mem_resp; PLRU is not updated for an abandoned miss.
- PLRU is updated only on hits. A filled line is marked MRU through its subsequent hit.
- Counters saturate at all-ones. clr_counters has priority over a same-cycle increment.
- The pmem strobes are held level until pmem_resp. Deasserting pmem_resp between cycles has no effect.

Decomposition:
- Package l2cache_pkg: state enum (IDLE, WRITEBACK, FILL); PLRU_W=NUM_WAYS-1 helper; onehot-to-index and lowest-set-bit functions.
- Sub-module plru_tree (parameter NUM_WAYS), combinational:
  - inputs: tree bits, access way;
  - outputs: victim way, updated tree bits.
- The controller holds the NUM_SETS x PLRU_W register array.

Test Plan:
- Read hit: NUM_WAYS=4, hit_vec=0100, mem_read=1 -> mem_resp the same cycle, way_sel=0100, hit_count=1, no pmem activity.
- Write hit: hit_vec=0001, mem_write=1 -> load_data=1, data_in_sel=1, set_dirty=1, mem_resp=1, way_sel=0001.
- Clean miss with invalid way: valid_vec=1011, hit_vec=0 -> victim 0100, FILL, pmem_read until pmem_resp after 5 cycles, load_tag/load_data/load_valid pulsed, then hit -> mem_resp; miss_count=1.
- Dirty PLRU eviction:
  - Setup: all ways valid; hits to ways 0,1,2,3 in order on set 3; then a miss, with dirty_vec having the PLRU victim way 0 dirty.
  - Required: WRITEBACK with pmem_write and way_sel=0001, then FILL, wb_count=1; PLRU of other sets is unchanged.
- Reset mid-FILL: drop rst_n during pmem_read -> pmem_read=0 immediately, state IDLE, counters 0, no mem_resp.
- Counter saturation/clear: CNT_W=3, 9 hits -> hit_count=7; clr_counters asserted with a hit -> hit_count=0.

Source files
------------

// File: rtl/l2cache_pkg.sv
// l2cache_pkg
// Shared types and helpers for the N-way L2 cache controller.
//   state_t        : controller state (IDLE, WRITEBACK, FILL)
//   plru_w()       : number of tree-PLRU bits for a given associativity
//   lowest_set_bit : index of the lowest set bit of a vector (0 if none)
//   onehot_to_idx  : index of the single set bit of a one-hot vector
package l2cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    // Widest associativity the helper functions accept.
    localparam int MAX_WAYS = 64;

    function automatic int plru_w(input int num_ways);
        return num_ways - 1;
    endfunction

    function automatic int unsigned lowest_set_bit(input logic [MAX_WAYS-1:0] vec);
        int unsigned idx;
        idx = 0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = int'(i);
        end
        return idx;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_WAYS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (vec[i]) idx = idx | int'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/l2cache_ctrl_nway_plru_tree.sv
// plru_tree
// Combinational tree-PLRU for one set. Tree bits are stored heap-style:
// node 0 is the root, children of node n are 2n+1 (lower half of the ways)
// and 2n+2 (upper half). A bit value of 1 means the victim lies in the
// upper half under that node.
//   tree       : current PLRU bits of the set
//   access_way : way being accessed (hit way)
//   victim_way : way the tree currently points at
//   tree_next  : tree bits after marking access_way most recently used
module plru_tree
    import l2cache_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [plru_w(NUM_WAYS)-1:0] tree,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic [plru_w(NUM_WAYS)-1:0] tree_next
);

    localparam int LEVELS = $clog2(NUM_WAYS);

    always_comb begin : victim_walk
        int node;
        node       = 0;
        victim_way = '0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            victim_way[LEVELS-1-lvl] = tree[node];
            node = 2 * node + 1 + (tree[node] ? 1 : 0);
        end
    end

    // Every node on the path to the accessed way is flipped to point away
    // from it; nodes off the path keep their value.
    always_comb begin : update_walk
        int node;
        logic dir;
        node      = 0;
        tree_next = tree;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            dir             = access_way[LEVELS-1-lvl];
            tree_next[node] = ~dir;
            node = 2 * node + 1 + (dir ? 1 : 0);
        end
    end

endmodule

// File: rtl/l2cache_ctrl_nway.sv
// l2cache_ctrl_nway
// N-way set-associative L2 cache controller: hit service, dirty-victim
// writeback and line fill against physical memory, per-set tree-PLRU
// replacement and saturating hit/miss/writeback counters.
//
// State table
//   state     | meaning
//   IDLE      | wait for request; service hits, detect misses, pick victim
//   WRITEBACK | write latched dirty victim to pmem (victim tag address)
//   FILL      | read line from pmem into latched victim way
//
// Ports
//   clk, rst_n                       : clock, async active-low reset
//   mem_read, mem_write, set_idx     : request from L1/arbiter
//   mem_resp                         : request complete (one-cycle pulse)
//   hit_vec, valid_vec, dirty_vec    : per-way status of the indexed set
//   pmem_resp/read/write/addr_sel    : physical memory handshake
//   way_sel, load_*, data_in_sel,
//   set_dirty, clr_dirty             : L2 datapath controls
//   miss_pulse                       : one-cycle pulse per detected miss
//   clr_counters                     : synchronous counter clear
//   hit_count, miss_count, wb_count  : saturating performance counters
module l2cache_ctrl_nway
    import l2cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    parameter int SET_W    = $clog2(NUM_SETS),
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [SET_W-1:0]    set_idx,
    output logic                mem_resp,
    input  logic [NUM_WAYS-1:0] hit_vec,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic [NUM_WAYS-1:0] dirty_vec,
    input  logic                pmem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic                pmem_addr_sel,
    output logic [NUM_WAYS-1:0] way_sel,
    output logic                load_tag,
    output logic                load_data,
    output logic                load_valid,
    output logic                data_in_sel,
    output logic                set_dirty,
    output logic                clr_dirty,
    output logic                miss_pulse,
    input  logic                clr_counters,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count,
    output logic [CNT_W-1:0]    wb_count
);

    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int PLRU_W = plru_w(NUM_WAYS);

    state_t              state_q, state_d;
    logic [PLRU_W-1:0]   plru_q [NUM_SETS];
    logic [WAY_W-1:0]    victim_q;

    logic                req;
    logic                any_hit;
    logic                any_invalid;
    logic [NUM_WAYS-1:0] hit_onehot;
    logic [NUM_WAYS-1:0] invalid_vec;
    logic [WAY_W-1:0]    hit_idx;
    logic [WAY_W-1:0]    inv_idx;
    logic [WAY_W-1:0]    plru_victim;
    logic [PLRU_W-1:0]   plru_upd;
    logic [WAY_W-1:0]    miss_victim;
    logic                victim_dirty;
    logic [NUM_WAYS-1:0] victim_onehot;
    logic                hit_ev;
    logic                miss_ev;
    logic                wb_done;

    assign req         = mem_read | mem_write;
    assign any_hit     = |hit_vec;
    assign invalid_vec = ~valid_vec;
    assign any_invalid = |invalid_vec;

    // Multiple hits are illegal; isolate the lowest one so the rest of the
    // logic always sees a clean one-hot hit.
    assign hit_onehot = hit_vec & (~hit_vec + NUM_WAYS'(1));
    assign hit_idx    = WAY_W'(onehot_to_idx(MAX_WAYS'(hit_onehot)));
    assign inv_idx    = WAY_W'(lowest_set_bit(MAX_WAYS'(invalid_vec)));

    plru_tree #(
        .NUM_WAYS(NUM_WAYS)
    ) u_plru_tree (
        .tree      (plru_q[set_idx]),
        .access_way(hit_idx),
        .victim_way(plru_victim),
        .tree_next (plru_upd)
    );

    // Empty ways are always filled before anything is evicted.
    assign miss_victim   = any_invalid ? inv_idx : plru_victim;
    assign victim_dirty  = valid_vec[miss_victim] & dirty_vec[miss_victim];
    assign victim_onehot = NUM_WAYS'(1) << victim_q;

    // IDLE outputs depend on the live request, so they are qualified with
    // rst_n to stay quiet while reset is held.
    assign hit_ev  = rst_n && (state_q == IDLE) && req && any_hit;
    assign miss_ev = rst_n && (state_q == IDLE) && req && !any_hit;
    assign wb_done = (state_q == WRITEBACK) && pmem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_ev) victim_q <= miss_victim;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b1;
        way_sel       = '0;
        load_tag      = 1'b0;
        load_data     = 1'b0;
        load_valid    = 1'b0;
        data_in_sel   = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        miss_pulse    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_ev) begin
                    mem_resp = 1'b1;
                    way_sel  = hit_onehot;
                    if (mem_write) begin
                        load_data   = 1'b1;
                        data_in_sel = 1'b1;
                        set_dirty   = 1'b1;
                    end
                end else if (miss_ev) begin
                    miss_pulse = 1'b1;
                    state_d    = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_onehot;
                if (pmem_resp) begin
                    clr_dirty = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b0;
                data_in_sel   = 1'b0;
                way_sel       = victim_onehot;
                if (pmem_resp) begin
                    load_tag   = 1'b1;
                    load_data  = 1'b1;
                    load_valid = 1'b1;
                    clr_dirty  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Replacement state moves only on hits; a freshly filled line becomes
    // MRU when the replayed request hits it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else if (hit_ev) begin
            plru_q[set_idx] <= plru_upd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (clr_counters) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_ev  && (hit_count  != '1)) hit_count  <= hit_count  + CNT_W'(1);
            if (miss_ev && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
            if (wb_done && (wb_count   != '1)) wb_count   <= wb_count   + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_l2cache_ctrl_nway.sv
module tb_l2cache_ctrl_nway;

    localparam int NW   = 4;
    localparam int NS   = 8;
    localparam int SW   = 3;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    // bit positions inside the packed strobe vector
    localparam int B_RESP = 10, B_PR = 9, B_PW = 8, B_ASEL = 7, B_LT = 6, B_LD = 5;
    localparam int B_LV = 4, B_DSEL = 3, B_SD = 2, B_CD = 1, B_MP = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write, mem_resp;
    logic [SW-1:0] set_idx;
    logic [NW-1:0] hit_vec, valid_vec, dirty_vec, way_sel;
    logic          pmem_resp, pmem_read, pmem_write, pmem_addr_sel;
    logic          load_tag, load_data, load_valid, data_in_sel;
    logic          set_dirty, clr_dirty, miss_pulse, clr_counters;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    l2cache_ctrl_nway #(
        .NUM_WAYS(NW), .NUM_SETS(NS), .SET_W(SW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .set_idx(set_idx), .mem_resp(mem_resp), .hit_vec(hit_vec),
        .valid_vec(valid_vec), .dirty_vec(dirty_vec), .pmem_resp(pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
        .way_sel(way_sel), .load_tag(load_tag), .load_data(load_data),
        .load_valid(load_valid), .data_in_sel(data_in_sel), .set_dirty(set_dirty),
        .clr_dirty(clr_dirty), .miss_pulse(miss_pulse), .clr_counters(clr_counters),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase of the miss sequence, latched victim, and a
    // per-way last-hit timestamp from which tree-PLRU victims are derived.
    int              m_phase;   // 0 idle, 1 writeback, 2 fill
    int              m_victim;
    longint unsigned ts [NS][NW];
    longint unsigned now;
    int              m_hit, m_miss, m_wb;

    logic [10:0]   s_str;
    logic [NW-1:0] s_ws;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowbit(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) if (v[i]) return i;
        return 0;
    endfunction

    // At each tree node the victim lies in the half that was hit less
    // recently; with no hits under a node the lower half is chosen.
    function automatic int plru_victim(input int s);
        int lo, size, half;
        longint unsigned ml, mr;
        lo = 0;
        size = NW;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < half; i++) begin
                if (ts[s][lo+i] > ml) ml = ts[s][lo+i];
                if (ts[s][lo+half+i] > mr) mr = ts[s][lo+half+i];
            end
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_victim = 0;
        now = 0;
        m_hit = 0;
        m_miss = 0;
        m_wb = 0;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) ts[s][w] = 0;
    endtask

    task automatic model_step();
        int v;
        case (m_phase)
            0: if (mem_read || mem_write) begin
                if (hit_vec != 0) begin
                    now++;
                    ts[set_idx][lowbit(hit_vec)] = now;
                    if (m_hit < CMAX) m_hit++;
                end else begin
                    v = -1;
                    for (int i = NW - 1; i >= 0; i--) if (!valid_vec[i]) v = i;
                    if (v < 0) v = plru_victim(int'(set_idx));
                    m_victim = v;
                    if (m_miss < CMAX) m_miss++;
                    m_phase = (valid_vec[v] && dirty_vec[v]) ? 1 : 2;
                end
            end
            1: if (pmem_resp) begin
                if (m_wb < CMAX) m_wb++;
                m_phase = 2;
            end
            default: if (pmem_resp) m_phase = 0;
        endcase
        if (clr_counters) begin
            m_hit = 0;
            m_miss = 0;
            m_wb = 0;
        end
    endtask

    task automatic compare();
        logic [10:0]   e;
        logic [NW-1:0] ews;
        e   = 11'h080;
        ews = '0;
        case (m_phase)
            0: if (rst_n && (mem_read || mem_write)) begin
                if (hit_vec != 0) begin
                    e[B_RESP] = 1'b1;
                    ews = NW'(1) << lowbit(hit_vec);
                    if (mem_write) begin
                        e[B_LD] = 1'b1;
                        e[B_DSEL] = 1'b1;
                        e[B_SD] = 1'b1;
                    end
                end else begin
                    e[B_MP] = 1'b1;
                end
            end
            1: begin
                e[B_PW] = 1'b1;
                ews = NW'(1) << m_victim;
                if (pmem_resp) e[B_CD] = 1'b1;
            end
            default: begin
                e[B_PR] = 1'b1;
                e[B_ASEL] = 1'b0;
                ews = NW'(1) << m_victim;
                if (pmem_resp) begin
                    e[B_LT] = 1'b1;
                    e[B_LD] = 1'b1;
                    e[B_LV] = 1'b1;
                    e[B_CD] = 1'b1;
                end
            end
        endcase
        s_str = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_tag, load_data,
                 load_valid, data_in_sel, set_dirty, clr_dirty, miss_pulse};
        s_ws = way_sel;
        chk("strobes", 32'(s_str), 32'(e));
        chk("way_sel", 32'(s_ws), 32'(ews));
        chk("counters", 32'({hit_count, miss_count, wb_count}),
            32'({CW'(m_hit), CW'(m_miss), CW'(m_wb)}));
    endtask

    // Entered 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        #4;
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reset_check();
        chk("rst_strobes", 32'({mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_tag,
            load_data, load_valid, data_in_sel, set_dirty, clr_dirty, miss_pulse}), 32'h080);
        chk("rst_way_sel", 32'(way_sel), 32'h0);
        chk("rst_counters", 32'({hit_count, miss_count, wb_count}), 32'h0);
    endtask

    // A live hitting request is held into reset to show IDLE outputs stay quiet.
    task automatic do_reset();
        mem_read = 1'b1;
        mem_write = 1'b0;
        hit_vec = 4'b0001;
        rst_n = 1'b0;
        #1;
        reset_check();
        model_reset();
        mem_read = 1'b0;
        hit_vec = '0;
        pmem_resp = 1'b0;
        clr_counters = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit req_on;
        int k;
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        set_idx = '0;
        hit_vec = '0;
        valid_vec = '0;
        dirty_vec = '0;
        pmem_resp = 1'b0;
        clr_counters = 1'b0;
        model_reset();
        #3;
        reset_check();
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // read hit on set 1, way 2
        set_idx = 3'd1; valid_vec = 4'b1111; hit_vec = 4'b0100; mem_read = 1'b1;
        cycle();
        chk("rd_hit_resp", 32'(s_str[B_RESP]), 32'h1);
        chk("rd_hit_way", 32'(s_ws), 32'h4);
        chk("rd_hit_no_pmem", 32'({s_str[B_PR], s_str[B_PW]}), 32'h0);
        chk("rd_hit_count", 32'(hit_count), 32'h1);

        // write hit on set 1, way 0
        mem_read = 1'b0; mem_write = 1'b1; hit_vec = 4'b0001;
        cycle();
        chk("wr_hit_ctl", 32'({s_str[B_RESP], s_str[B_LD], s_str[B_DSEL], s_str[B_SD]}), 32'hF);
        chk("wr_hit_way", 32'(s_ws), 32'h1);

        // clean miss into invalid way 2 of set 2, fill answered on 5th cycle
        mem_write = 1'b0; mem_read = 1'b1; hit_vec = '0;
        set_idx = 3'd2; valid_vec = 4'b1011; dirty_vec = 4'b1111;
        cycle();
        chk("miss_pulse", 32'(s_str[B_MP]), 32'h1);
        chk("miss_no_way", 32'(s_ws), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fill_read", 32'({s_str[B_PR], s_ws}), 32'h14);
        end
        pmem_resp = 1'b1;
        cycle();
        chk("fill_loads", 32'({s_str[B_LT], s_str[B_LD], s_str[B_LV]}), 32'h7);
        pmem_resp = 1'b0; hit_vec = 4'b0100; valid_vec = 4'b1111;
        cycle();
        chk("replay_resp", 32'(s_str[B_RESP]), 32'h1);
        chk("miss_count", 32'(miss_count), 32'h1);

        // hits 0..3 on set 3, then miss evicting dirty PLRU victim way 0
        set_idx = 3'd3; dirty_vec = 4'b0000;
        for (int w = 0; w < NW; w++) begin
            hit_vec = NW'(1) << w;
            cycle();
        end
        hit_vec = '0; dirty_vec = 4'b0001;
        cycle();
        pmem_resp = 1'b1;
        cycle();
        chk("wb_write", 32'({s_str[B_PW], s_str[B_ASEL], s_ws}), 32'h31);
        chk("wb_clr_dirty", 32'(s_str[B_CD]), 32'h1);
        cycle();
        chk("wb_count", 32'(wb_count), 32'h1);
        mem_read = 1'b0; pmem_resp = 1'b0;
        cycle();

        // set 1 replacement history must be its own: victim way 3
        set_idx = 3'd1; mem_read = 1'b1; dirty_vec = 4'b0000;
        cycle();
        cycle();
        chk("set1_victim", 32'(s_ws), 32'h8);
        pmem_resp = 1'b1;
        cycle();
        pmem_resp = 1'b0; mem_read = 1'b0;
        cycle();

        // counter clear, saturation, clear beating a same-cycle hit
        clr_counters = 1'b1;
        cycle();
        chk("clr_hit", 32'(hit_count), 32'h0);
        clr_counters = 1'b0; set_idx = 3'd5; mem_read = 1'b1; hit_vec = 4'b0010;
        for (int i = 0; i < 9; i++) cycle();
        chk("sat_hit", 32'(hit_count), 32'h7);
        clr_counters = 1'b1;
        cycle();
        chk("clr_prio", 32'(hit_count), 32'h0);
        clr_counters = 1'b0; mem_read = 1'b0; hit_vec = '0;
        cycle();

        // reset while filling
        set_idx = 3'd4; valid_vec = 4'b0000; mem_read = 1'b1;
        cycle();
        cycle();
        chk("pre_rst_fill", 32'(s_str[B_PR]), 32'h1);
        do_reset();

        // randomized traffic
        req_on = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!req_on && $urandom_range(0, 2) == 0) begin
                req_on = 1'b1;
                k = $urandom_range(0, 3);
                mem_read = (k != 1);
                mem_write = (k != 0);
                set_idx = SW'($urandom);
            end else if (req_on && m_phase != 0 && $urandom_range(0, 39) == 0) begin
                req_on = 1'b0;
                mem_read = 1'b0;
                mem_write = 1'b0;
            end
            k = $urandom_range(0, 9);
            if (k < 5) hit_vec = '0;
            else if (k < 9) hit_vec = NW'(1) << $urandom_range(0, NW - 1);
            else hit_vec = NW'($urandom);
            valid_vec = ($urandom_range(0, 1) == 1) ? '1 : NW'($urandom);
            dirty_vec = NW'($urandom);
            pmem_resp = ($urandom_range(0, 3) == 0);
            clr_counters = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                req_on = 1'b0;
            end else begin
                cycle();
                if (s_str[B_RESP]) begin
                    req_on = 1'b0;
                    mem_read = 1'b0;
                    mem_write = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
